gbsha_mac_sequencer: RTL and testbench

GBSHA_MAC_SEQUENCER -- requirements
Module: gbsha_mac_sequencer

---
 rtl/gbsha_mac_sequencer.sv | 130 +++++++++++++
 tb/tb_gbsha_mac_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gbsha_mac_sequencer.sv
// Sequencer for an external 4-tap MAC: loads mode and taps, streams samples and collects results.
// Optional MAC_SEQ_UNDERRUN_EN adds underrun_cnt, a saturating count of zero-inserted READ cycles.
module gbsha_mac_sequencer #(
  parameter int N_TAPS = 4,
  parameter int BW_in  = 6,
  parameter int BW_out = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cfg_start,
  input  logic                    cfg_stop,
  input  logic                    cfg_lsb,
  input  logic [N_TAPS*BW_in-1:0] coef_data,
  output logic                    cfg_busy,
  input  logic                    s_valid,
  input  logic [BW_in-1:0]        s_data,
  output logic                    s_ready,
  output logic                    r_valid,
  output logic [2*BW_out-1:0]     r_data,
  output logic                    mac_rst,
  output logic [BW_in-1:0]        mac_in,
  input  logic [BW_out-1:0]       mac_out
`ifdef MAC_SEQ_UNDERRUN_EN
  ,
  output logic [7:0]              underrun_cnt
`endif
);

  localparam int LSB_W = 5;
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CFG   = 3'd1;
  localparam logic [2:0] S_COEF0 = 3'd2;
  localparam logic [2:0] S_COEF1 = 3'd3;
  localparam logic [2:0] S_COEF2 = 3'd4;
  localparam logic [2:0] S_COEF3 = 3'd5;
  localparam logic [2:0] S_RUN   = 3'd6;

  logic [2:0]                   state_q, state_d;
  logic                         phase_q, phase_d;  // 0 = READ, 1 = SHIFT
  logic                         lsb_q;
  logic [N_TAPS-1:0][BW_in-1:0] coef_q;
  logic [1:0]                   vld_pipe_q;        // [0] MSB capture due, [1] LSB capture due
  logic [BW_out-1:0]            msb_q;
  logic [LSB_W-1:0]             lsb5_q;
  logic                         r_valid_q;
  logic                         start_acc, stop_acc, read_fire;

  assign start_acc = (state_q == S_IDLE) && cfg_start;
  assign stop_acc  = (state_q == S_RUN) && cfg_stop;
  assign read_fire = (state_q == S_RUN) && !phase_q && !cfg_stop;

  assign s_ready  = read_fire;
  assign cfg_busy = (state_q != S_IDLE);
  assign mac_rst  = reset || (state_q == S_IDLE);
  assign r_valid  = r_valid_q;
  assign r_data   = {msb_q, 3'b000, lsb5_q};

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    mac_in  = '0;
    case (state_q)
      S_IDLE:  if (cfg_start) state_d = S_CFG;
      S_CFG:   begin mac_in = BW_in'(lsb_q); state_d = S_COEF0; end
      // The MAC expects the oldest-sample tap first.
      S_COEF0: begin mac_in = coef_q[3]; state_d = S_COEF1; end
      S_COEF1: begin mac_in = coef_q[2]; state_d = S_COEF2; end
      S_COEF2: begin mac_in = coef_q[1]; state_d = S_COEF3; end
      S_COEF3: begin mac_in = coef_q[0]; state_d = S_RUN; phase_d = 1'b0; end
      S_RUN: begin
        if (cfg_stop) begin
          state_d = S_IDLE;
          phase_d = 1'b0;
        end else begin
          phase_d = lsb_q & ~phase_q;
          if (!phase_q && s_valid) mac_in = s_data;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      phase_q    <= 1'b0;
      lsb_q      <= 1'b0;
      coef_q     <= '0;
      vld_pipe_q <= '0;
      msb_q      <= '0;
      lsb5_q     <= '0;
      r_valid_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      r_valid_q <= 1'b0;
      if (start_acc) begin
        lsb_q  <= cfg_lsb;
        coef_q <= coef_data;
      end
      // A stop drops every result still travelling through the MAC.
      vld_pipe_q <= stop_acc ? 2'b00 : {vld_pipe_q[0] & lsb_q, read_fire};
      if (vld_pipe_q[0] && !stop_acc) begin
        msb_q <= mac_out;
        if (!lsb_q) begin
          lsb5_q    <= '0;
          r_valid_q <= 1'b1;
        end
      end
      if (vld_pipe_q[1] && !stop_acc) begin
        lsb5_q    <= mac_out[LSB_W-1:0];
        r_valid_q <= 1'b1;
      end
    end
  end

`ifdef MAC_SEQ_UNDERRUN_EN
  logic [7:0] underrun_q;

  always_ff @(posedge clk) begin
    if (reset || start_acc)
      underrun_q <= '0;
    else if (read_fire && !s_valid && underrun_q != 8'hFF)
      underrun_q <= underrun_q + 8'd1;
  end

  assign underrun_cnt = underrun_q;
`endif

endmodule

// File: tb/tb_gbsha_mac_sequencer.sv
// Bench for gbsha_mac_sequencer: behavioural MAC stand-in plus a result scoreboard with latency check.
module tb_gbsha_mac_sequencer;
  logic        clk = 1'b0;
  logic        reset, cfg_start, cfg_stop, cfg_lsb;
  logic [23:0] coef_data;
  logic        cfg_busy, s_valid;
  logic [5:0]  s_data;
  logic        s_ready, r_valid;
  logic [15:0] r_data;
  logic        mac_rst;
  logic [5:0]  mac_in;
  logic [7:0]  mac_out;
`ifdef MAC_SEQ_UNDERRUN_EN
  logic [7:0]  underrun_cnt;
`endif

  int total = 0, bad = 0, cyc = 0;
  bit poke_start = 0;

  typedef struct {logic [15:0] d; int due;} exp_t;
  exp_t sb[$];
  exp_t me;

  logic signed [5:0] sb_tap[4], sb_hist[4], mtap[4], mhist[4];
  bit          sb_lsb;
  int          mstep;
  bit          mlsb, mph;
  logic [12:0] msum, mnext;

  gbsha_mac_sequencer dut (
    .clk(clk), .reset(reset), .cfg_start(cfg_start), .cfg_stop(cfg_stop),
    .cfg_lsb(cfg_lsb), .coef_data(coef_data), .cfg_busy(cfg_busy),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .r_valid(r_valid), .r_data(r_data), .mac_rst(mac_rst),
    .mac_in(mac_in), .mac_out(mac_out)
`ifdef MAC_SEQ_UNDERRUN_EN
    , .underrun_cnt(underrun_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [12:0] fir4(input logic signed [5:0] t[4],
                                       input logic signed [5:0] x0, x1, x2, x3);
    int s;
    s = int'(t[0]) * int'(x0) + int'(t[1]) * int'(x1)
      + int'(t[2]) * int'(x2) + int'(t[3]) * int'(x3);
    return s[12:0];
  endfunction

  // MAC stand-in: mode bit, taps (tap 3 first), then one sample per READ; LSB5 follows in SHIFT.
  assign mnext = fir4(mtap, mac_in, mhist[0], mhist[1], mhist[2]);
  always @(posedge clk) begin
    if (mac_rst) begin
      mstep   <= 0;
      mph     <= 0;
      mhist   <= '{default: '0};
      mac_out <= 8'h00;
    end else if (mstep == 0) begin
      mlsb  <= mac_in[0];
      mstep <= 1;
    end else if (mstep < 5) begin
      mtap[4-mstep] <= mac_in;
      mstep         <= mstep + 1;
    end else if (mlsb && mph) begin
      mac_out <= {3'b000, msum[4:0]};
      mph     <= 0;
    end else begin
      mhist[0] <= mac_in; mhist[1] <= mhist[0]; mhist[2] <= mhist[1]; mhist[3] <= mhist[2];
      msum     <= mnext;
      mac_out  <= mnext[12:5];
      mph      <= mlsb;
    end
  end

  always @(negedge clk) begin
    if (r_valid === 1'b1) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_r_valid: got pulse with r_data=%h at cycle %0d, required no pulse", r_data, cyc);
      end else begin
        me = sb.pop_front();
        if (r_data !== me.d || cyc != me.due) begin
          bad++;
          $display("FAIL r_data: got %h at cycle %0d, required %h at cycle %0d", r_data, cyc, me.d, me.due);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation bound expired");
    $fatal(1);
  end

  task automatic apply_poke;
    cfg_start = poke_start;
    if (poke_start) begin
      coef_data = 24'($urandom);
      cfg_lsb   = ~sb_lsb;
    end
  endtask

  task automatic start_cfg(input bit lsb, input logic [23:0] coef);
    @(posedge clk); #2;
    cfg_start = 1; cfg_lsb = lsb; coef_data = coef; s_valid = 0; cfg_stop = 0;
    #1; total++;
    if (cfg_busy !== 1'b0 || mac_rst !== 1'b1 || mac_in !== 6'd0) begin
      bad++; $display("FAIL idle_out: busy=%b mac_rst=%b mac_in=%h, required 0 1 00", cfg_busy, mac_rst, mac_in);
    end
    @(posedge clk); #2;
    cfg_start = 0; cfg_lsb = ~lsb; coef_data = ~coef; s_valid = 1;
    #1; total++;
    if (cfg_busy !== 1'b1 || mac_rst !== 1'b0 || mac_in !== {5'b0, lsb} || s_ready !== 1'b0) begin
      bad++; $display("FAIL cfg_cycle: busy=%b mac_rst=%b mac_in=%h s_ready=%b, required 1 0 %h 0",
                      cfg_busy, mac_rst, mac_in, s_ready, {5'b0, lsb});
    end
`ifdef MAC_SEQ_UNDERRUN_EN
    total++;
    if (underrun_cnt !== 8'd0) begin
      bad++; $display("FAIL underrun_clear: got %0d, required 0", underrun_cnt);
    end
`endif
    for (int j = 0; j < 4; j++) begin
      @(posedge clk); #3; total++;
      if (mac_in !== coef[(3-j)*6 +: 6] || s_ready !== 1'b0) begin
        bad++; $display("FAIL coef_%0d: mac_in=%h s_ready=%b, required %h 0", j, mac_in, s_ready, coef[(3-j)*6 +: 6]);
      end
    end
    s_valid = 0;
    sb_lsb  = lsb;
    for (int k = 0; k < 4; k++) begin
      sb_tap[k]  = coef[k*6 +: 6];
      sb_hist[k] = '0;
    end
  endtask

  task automatic rd(input bit v, input logic [5:0] d, input bit use_c, input logic [15:0] c);
    logic [12:0] s;
    exp_t e;
    @(posedge clk); #2;
    s_valid = v; s_data = d; cfg_stop = 0;
    apply_poke();
    #1; total++;
    if (s_ready !== 1'b1 || mac_in !== (v ? d : 6'd0)) begin
      bad++; $display("FAIL read_cycle: s_ready=%b mac_in=%h, required 1 %h", s_ready, mac_in, (v ? d : 6'd0));
    end
    s = fir4(sb_tap, v ? d : 6'd0, sb_hist[0], sb_hist[1], sb_hist[2]);
    sb_hist[3] = sb_hist[2]; sb_hist[2] = sb_hist[1]; sb_hist[1] = sb_hist[0];
    sb_hist[0] = v ? d : 6'd0;
    e.d   = use_c ? c : {s[12:5], 3'b000, sb_lsb ? s[4:0] : 5'd0};
    e.due = cyc + (sb_lsb ? 3 : 2);
    sb.push_back(e);
  endtask

  task automatic sh;
    @(posedge clk); #2;
    s_valid = 1; s_data = 6'($urandom); cfg_stop = 0;
    apply_poke();
    #1; total++;
    if (s_ready !== 1'b0 || mac_in !== 6'd0) begin
      bad++; $display("FAIL shift_cycle: s_ready=%b mac_in=%h, required 0 00", s_ready, mac_in);
    end
  endtask

  task automatic stop_run;
    @(posedge clk); #2;
    cfg_stop = 1; s_valid = 1; s_data = 6'h15; cfg_start = 0;
    #1; total++;
    if (s_ready !== 1'b0 || mac_in !== 6'd0 || cfg_busy !== 1'b1) begin
      bad++; $display("FAIL stop_cycle: s_ready=%b mac_in=%h busy=%b, required 0 00 1", s_ready, mac_in, cfg_busy);
    end
    while (sb.size() > 0 && sb[sb.size()-1].due > cyc) sb.delete(sb.size()-1);
    @(posedge clk); #2;
    cfg_stop = 0; s_valid = 0;
    #1; total++;
    if (cfg_busy !== 1'b0 || mac_rst !== 1'b1 || s_ready !== 1'b0) begin
      bad++; $display("FAIL stop_idle: busy=%b mac_rst=%b s_ready=%b, required 0 1 0", cfg_busy, mac_rst, s_ready);
    end
    repeat (4) @(posedge clk);
    #3; total++;
    if (sb.size() != 0) begin
      bad++; $display("FAIL sb_drain: pending=%0d, required 0", sb.size());
    end
  endtask

  task automatic test_reset;
    reset = 1; cfg_start = 0; cfg_stop = 0; cfg_lsb = 0; coef_data = '0; s_valid = 0; s_data = '0;
    repeat (2) @(posedge clk);
    #3; total++;
    if (cfg_busy !== 1'b0 || r_valid !== 1'b0 || r_data !== 16'h0 || s_ready !== 1'b0 || mac_rst !== 1'b1) begin
      bad++; $display("FAIL reset_state: busy=%b r_valid=%b r_data=%h s_ready=%b mac_rst=%b, required 0 0 0000 0 1",
                      cfg_busy, r_valid, r_data, s_ready, mac_rst);
    end
`ifdef MAC_SEQ_UNDERRUN_EN
    total++;
    if (underrun_cnt !== 8'd0) begin
      bad++; $display("FAIL reset_underrun: got %0d, required 0", underrun_cnt);
    end
`endif
    @(posedge clk); #2;
    reset = 0; cfg_stop = 1;
    @(posedge clk); #3; total++;
    if (cfg_busy !== 1'b0 || mac_rst !== 1'b1) begin
      bad++; $display("FAIL idle_stop_ignored: busy=%b mac_rst=%b, required 0 1", cfg_busy, mac_rst);
    end
    cfg_stop = 0;
  endtask

  task automatic test_lsb_single;
    start_cfg(1, 24'h000001);
    rd(1, 6'd5, 1, 16'h0005);
    sh();
    rd(0, 6'd0, 0, 16'h0);
    sh();
    stop_run();
  endtask

  task automatic test_lsb_neg;
    start_cfg(1, 24'h00003F);
    rd(1, 6'd3, 1, 16'hFF1D);
    sh();
    rd(0, 6'd0, 0, 16'h0);
    sh();
    stop_run();
  endtask

  task automatic test_msb_ramp;
    start_cfg(0, {4{6'd16}});
    rd(1, 6'd16, 1, 16'h0800);
    rd(1, 6'd16, 1, 16'h1000);
    rd(1, 6'd16, 1, 16'h1800);
    rd(1, 6'd16, 1, 16'h2000);
    rd(1, 6'd16, 1, 16'h2000);
    rd(0, 6'd0, 0, 16'h0);
    stop_run();
  endtask

  task automatic test_underrun;
    start_cfg(0, 24'($urandom));
    rd(1, 6'($urandom), 0, 16'h0);
    rd(0, 6'd0, 0, 16'h0);
    rd(0, 6'd0, 0, 16'h0);
    rd(1, 6'($urandom), 0, 16'h0);
`ifdef MAC_SEQ_UNDERRUN_EN
    total++;
    if (underrun_cnt !== 8'd2) begin
      bad++; $display("FAIL underrun_count: got %0d, required 2", underrun_cnt);
    end
`endif
    rd(1, 6'($urandom), 0, 16'h0);
    stop_run();
  endtask

  task automatic test_reset_mid;
    @(posedge clk); #2;
    cfg_start = 1; cfg_lsb = 0; coef_data = {4{6'd16}};
    @(posedge clk); #2;
    cfg_start = 0;
    repeat (3) @(posedge clk);
    #2; reset = 1;
    #1; total++;
    if (mac_rst !== 1'b1 || cfg_busy !== 1'b1) begin
      bad++; $display("FAIL reset_in_coef2: mac_rst=%b busy=%b, required 1 1", mac_rst, cfg_busy);
    end
    @(posedge clk); #3; total++;
    if (cfg_busy !== 1'b0 || mac_rst !== 1'b1 || r_valid !== 1'b0) begin
      bad++; $display("FAIL reset_to_idle: busy=%b mac_rst=%b r_valid=%b, required 0 1 0", cfg_busy, mac_rst, r_valid);
    end
    reset = 0;
    @(posedge clk); #3; total++;
    if (mac_rst !== 1'b1 || cfg_busy !== 1'b0) begin
      bad++; $display("FAIL idle_after_reset: mac_rst=%b busy=%b, required 1 0", mac_rst, cfg_busy);
    end
    test_msb_ramp();
  endtask

  task automatic test_back_to_back;
    for (int it = 0; it < 4; it++) begin
      start_cfg(it[0], 24'($urandom));
      for (int n = 0; n < 14; n++) begin
        poke_start = (n == 5);
        if (sb_lsb && n[0]) sh();
        else rd($urandom_range(0, 3) != 0, 6'($urandom), 0, 16'h0);
        poke_start = 0;
      end
      stop_run();
    end
  endtask

  initial begin
    test_reset();
    test_lsb_single();
    test_lsb_neg();
    test_msb_ramp();
    test_underrun();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
